block_sender: RTL and testbench

- Per-channel requester-side controller for the 16-input round-robin link arbiter.
- Buffers 16-bit data blocks produced by channel processing in a circular store.
- Raises req while a complete block is queued.
- Streams exactly one word per ack cycle onto its 16-bit lane of the arbiter data bus. Drops req for at least one cycle after each block's last word, so the arbiter rotates to the next channel.

---
 rtl/block_sender_pkg.sv | 21 ++
 rtl/block_sender_ram.sv | 28 ++
 rtl/block_sender.sv | 158 +++++++++++++++
 tb/tb_block_sender.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_sender_pkg.sv
// Shared definitions for the per-channel block sender: lane width, K-codes,
// default buffer size, write FSM states and the stored entry format.
package block_sender_pkg;

    localparam int LANE_W     = 16;
    localparam int DEFAULT_AW = 10;

    localparam logic [LANE_W-1:0] CH_COMMA = 16'h00BC;
    localparam logic [LANE_W-1:0] CH_TRIG  = 16'h801C;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic              last;
        logic [LANE_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/block_sender_ram.sv
// Simple dual-port block store: one synchronous write port, one registered
// read port. A read of the address being written returns the old contents.
module block_sender_ram
    import block_sender_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    localparam int DEPTH = 1 << AW;

    entry_t mem [DEPTH];

    // Write the new entry and register the read data on every rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/block_sender.sv
// Requester-side link controller: queues complete blocks in a circular store,
// requests the arbiter while a block is ready and streams one word per ack.
module block_sender
    import block_sender_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANE_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              wr_last,
    output logic              req,
    input  logic              ack,
    output logic [LANE_W-1:0] dout,
    output logic [CW-1:0]     blk_cnt,
    output logic              overflow
);

    localparam logic [AW-1:0] P_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = '1;

    wr_state_t     state;
    wr_state_t     state_next;
    logic [AW-1:0] wp;
    logic [AW-1:0] cp;
    logic [AW-1:0] rp;
    logic [AW-1:0] wp_inc;
    logic [AW-1:0] raddr;
    logic          full;
    logic          cnt_sat;
    logic          we;
    logic          commit;
    logic          rollback;
    logic          ovf_next;
    logic          consume;
    logic          done;
    logic          prefetch_ok;
    logic [CW-1:0] blk_cnt_next;
    entry_t        wdata;
    entry_t        rdata;

    assign wp_inc     = wp + P_ONE;
    assign full       = (wp_inc == rp);
    assign wdata.last = wr_last;
    assign wdata.data = wr_data;

    // A word leaves only while our request is up, so the arbiter can never
    // pull from an uncommitted region of the store.
    assign consume = ack && req;
    assign done    = consume && rdata.last;
    assign cnt_sat = (blk_cnt == CNT_MAX) && !done;

    // The RAM output register is the prefetch: it re-reads mem[rp] each cycle
    // and advances one address ahead on a consuming edge.
    assign raddr       = consume ? (rp + P_ONE) : rp;
    assign prefetch_ok = !(we && (wp == raddr));

    block_sender_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Write FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // Write-side decode: store, commit, or roll back a block that cannot fit
    always_comb begin
        state_next = state;
        we         = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        ovf_next   = 1'b0;
        case (state)
            ACCEPT: begin
                if (wr_en) begin
                    if (full || (wr_last && cnt_sat)) begin
                        rollback = 1'b1;
                        ovf_next = 1'b1;
                        if (!wr_last) begin
                            state_next = DISCARD;
                        end
                    end else begin
                        we     = 1'b1;
                        commit = wr_last;
                    end
                end
            end
            DISCARD: begin
                if (wr_en && wr_last) begin
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    // Queued-block count: +1 on commit, -1 when a last word goes out
    always_comb begin
        blk_cnt_next = blk_cnt;
        case ({commit, done})
            2'b10:   blk_cnt_next = blk_cnt + C_ONE;
            2'b01:   blk_cnt_next = blk_cnt - C_ONE;
            default: blk_cnt_next = blk_cnt;
        endcase
    end

    // Write, commit and read pointers of the circular store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            cp <= '0;
            rp <= '0;
        end else begin
            if (we) begin
                wp <= wp_inc;
            end else if (rollback) begin
                wp <= cp;
            end
            if (commit) begin
                cp <= wp_inc;
            end
            rp <= raddr;
        end
    end

    // Registered arbiter-facing outputs; req drops for the cycle after a last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req      <= 1'b0;
            dout     <= '0;
            blk_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            blk_cnt  <= blk_cnt_next;
            overflow <= ovf_next;
            req      <= (blk_cnt_next != '0) && prefetch_ok && !done;
            if (consume) begin
                dout <= rdata.data;
            end
        end
    end

endmodule

// File: tb/tb_block_sender.sv
// Self-checking bench for block_sender: directed scenarios plus random traffic,
// all checked against a queue-based model of committed blocks.
module tb_block_sender;
    import block_sender_pkg::*;

    localparam int AW    = 3;
    localparam int CW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_last = 1'b0;
    logic          ack = 1'b0;
    logic          req;
    logic [15:0]   dout;
    logic [CW-1:0] blk_cnt;
    logic          overflow;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [16:0] store[$];
    logic [15:0] partial[$];
    bit          discarding;
    int          m_cnt;
    logic [15:0] exp_dout;
    bit          exp_ovf;
    bit          last_acked;
    bit          pop_err;
    bit          mon_en = 1'b0;
    int          low_run = 0;

    bit exp_req_seq [10] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
    int exp_cnt_seq [10] = '{2, 2, 1, 1, 1, 1, 0, 0, 0, 0};

    block_sender #(
        .AW (AW),
        .CW (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .wr_last  (wr_last),
        .req      (req),
        .ack      (ack),
        .dout     (dout),
        .blk_cnt  (blk_cnt),
        .overflow (overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, n_compared=%0d", n_compared);
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle of stimulus; ack behaves like an arbiter granting only a requester
    task automatic applyStimulus(input logic en, input logic last, input logic [15:0] data, input logic want_ack);
        wr_en   = en;
        wr_last = last;
        wr_data = data;
        ack     = want_ack && req;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic want_ack);
        repeat (n) applyStimulus(1'b0, 1'b0, CH_COMMA, want_ack);
    endtask

    task automatic writeBlock(input logic [15:0] base, input logic [15:0] step, input int len, input logic want_ack);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, (i == len - 1), 16'(base + step * i), want_ack);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        i = 0;
        while (blk_cnt != '0 && i < budget) begin
            applyStimulus(1'b0, 1'b0, CH_COMMA, 1'b1);
            i++;
        end
        idle(1, 1'b0);
        checkOutput(tag, blk_cnt, 0);
    endtask

    // Reference model: committed blocks as a word queue, open block as a list
    always @(posedge clk or posedge reset) begin : model
        int          occ;
        bit          done;
        logic [16:0] w;
        if (reset) begin
            store.delete();
            partial.delete();
            discarding = 1'b0;
            m_cnt      = 0;
            exp_dout   = '0;
            exp_ovf    = 1'b0;
            last_acked = 1'b0;
            pop_err    = 1'b0;
        end else begin
            occ     = store.size() + partial.size();
            done    = 1'b0;
            exp_ovf = 1'b0;
            if (ack) begin
                if (store.size() == 0) begin
                    pop_err = 1'b1;
                end else begin
                    w        = store.pop_front();
                    exp_dout = w[15:0];
                    done     = w[16];
                end
            end
            if (wr_en) begin
                if (discarding) begin
                    if (wr_last) discarding = 1'b0;
                end else if (occ == DEPTH - 1 || (wr_last && m_cnt == CMAX && !done)) begin
                    partial.delete();
                    exp_ovf = 1'b1;
                    if (!wr_last) discarding = 1'b1;
                end else begin
                    partial.push_back(wr_data);
                    if (wr_last) begin
                        for (int i = 0; i < partial.size(); i++) begin
                            store.push_back({(i == partial.size() - 1), partial[i]});
                        end
                        partial.delete();
                        m_cnt++;
                    end
                end
            end
            if (done) m_cnt--;
            last_acked = done;
        end
    end

    // Per-cycle comparison of DUT outputs against the model, on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("blk_cnt", blk_cnt, m_cnt);
            checkOutput("overflow", overflow, exp_ovf);
            checkOutput("dout", dout, exp_dout);
            checkOutput("ack_into_empty", pop_err, 0);
            if (last_acked) checkOutput("req_gap", req, 0);
            if (req) checkOutput("req_has_block", (m_cnt > 0), 1);
            if (m_cnt > 0 && !req) low_run++;
            else low_run = 0;
            checkOutput("req_live", (low_run < 3), 1);
        end
    end

    initial begin
        bit seen;
        int ovf_seen;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        bit r_seq [10];
        int c_seq [10];

        @(posedge clk);
        #2;
        mon_en = 1'b1;
        checkOutput("rst_req", req, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_blk_cnt", blk_cnt, 0);
        checkOutput("rst_overflow", overflow, 0);
        reset = 1'b0;

        $display("[TB] single block");
        writeBlock(16'h1111, 16'h1111, 4, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (req) seen = 1'b1;
            idle(1, 1'b0);
        end
        checkOutput("t1_req_rise", seen, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, CH_COMMA, 1'b1);
            checkOutput("t1_word", dout, 16'(16'h1111 * (k + 1)));
        end
        checkOutput("t1_req_low", req, 0);
        checkOutput("t1_cnt", blk_cnt, 0);
        idle(2, 1'b0);

        $display("[TB] ack stalls");
        writeBlock(16'h1111, 16'h1111, 4, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, CH_COMMA, pat[i]);
        checkOutput("t2_dout", dout, 16'h4444);
        checkOutput("t2_cnt", blk_cnt, 0);
        idle(2, 1'b0);

        $display("[TB] back-to-back blocks");
        writeBlock(16'hA000, 16'h0001, 3, 1'b0);
        writeBlock(16'hB000, 16'h0001, 3, 1'b0);
        idle(2, 1'b0);
        checkOutput("t3_cnt2", blk_cnt, 2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, CH_COMMA, 1'b1);
            r_seq[i] = req;
            c_seq[i] = int'(blk_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput("t3_req_seq", r_seq[i], exp_req_seq[i]);
            checkOutput("t3_cnt_seq", c_seq[i], exp_cnt_seq[i]);
        end
        idle(1, 1'b0);

        $display("[TB] simultaneous commit and last ack");
        writeBlock(16'hC000, 16'h0001, 2, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'hD000, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'hD001, 1'b1);
        checkOutput("t4_cnt", blk_cnt, 1);
        checkOutput("t4_req_gap", req, 0);
        idle(1, 1'b0);
        checkOutput("t4_req_back", req, 1);
        drain("t4_drain", 20);

        $display("[TB] overflow");
        writeBlock(16'h5000, 16'h0001, 5, 1'b0);
        ovf_seen = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 3), 16'(16'h6000 + i), 1'b0);
            ovf_seen += int'(overflow);
        end
        idle(1, 1'b0);
        checkOutput("t5_ovf_pulses", ovf_seen, 1);
        checkOutput("t5_cnt", blk_cnt, 1);
        drain("t5_drain", 20);
        writeBlock(16'h7000, 16'h0001, 2, 1'b0);
        idle(1, 1'b0);
        drain("t5_after", 20);

        $display("[TB] async reset mid-transfer");
        writeBlock(16'h8000, 16'h0001, 3, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b0, 1'b0, CH_COMMA, 1'b1);
        ack   = 1'b0;
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("t6_req", req, 0);
        checkOutput("t6_dout", dout, 0);
        checkOutput("t6_cnt", blk_cnt, 0);
        checkOutput("t6_ovf", overflow, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        writeBlock(16'h9000, 16'h0001, 3, 1'b0);
        idle(1, 1'b0);
        checkOutput("t6_req_new", req, 1);
        drain("t6_drain", 20);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            logic en;
            en = 1'($urandom_range(0, 1));
            applyStimulus(en, en && ($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 9) < 7));
        end
        drain("rand_drain", 200);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
